// File: rtl/neuron_step_ctrl.sv
// neuron_step_ctrl: sequences a multi-timestep run of the external neuron
// update datapath. Holds the membrane-voltage vector, takes one current
// vector per step, applies threshold spike detection and optional reset,
// emits one spike record per step and returns the final voltages.
module neuron_step_ctrl #(
   parameter int LANES          = 16,
   parameter int DW             = 32,
   parameter int STEP_W         = 8,
   parameter int CNT_W          = 16,
   parameter bit RESET_ON_SPIKE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            cfg_vl,
   input  logic [DW-1:0]         cfg_vt,
   input  logic [STEP_W-1:0]     cfg_steps,
   input  logic [LANES*DW-1:0]   vol_init,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   input  logic                  cur_valid,
   output logic                  cur_ready,
   input  logic [LANES*DW-1:0]   cur_data,
   output logic [LANES*DW-1:0]   dp_vol,
   output logic [LANES*DW-1:0]   dp_cur,
   output logic [DW-1:0]         dp_vt,
   output logic [1:0]            dp_vl,
   input  logic [LANES*DW-1:0]   dp_vol_out,
   output logic                  spk_valid,
   input  logic                  spk_ready,
   output logic [LANES-1:0]      spk_mask,
   output logic [STEP_W-1:0]     spk_step,
   output logic [LANES*DW-1:0]   vol_final,
   output logic [CNT_W-1:0]      spike_total
);

   localparam int PC_W = $clog2(LANES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_CUR,
      S_UPDATE,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [LANES*DW-1:0]   vol_q, vol_d;
   logic [LANES*DW-1:0]   cur_q, cur_d;
   logic [DW-1:0]         vt_q, vt_d;
   logic [1:0]            vl_q, vl_d;
   logic [STEP_W-1:0]     steps_q, steps_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic [STEP_W-1:0]     spk_step_q, spk_step_d;
   logic [LANES-1:0]      mask_q, mask_d;
   logic [CNT_W-1:0]      total_q, total_d;
   logic                  err_q, err_d;

   logic [LANES*DW-1:0]   upd_vol;
   logic [LANES-1:0]      upd_mask;
   logic [PC_W-1:0]       upd_cnt;
   logic [DW-1:0]         lane_res;
   logic [STEP_W-1:0]     step_inc;
   int                    act_n;

   // Number of active lanes for a vector-length code (11 never reaches here).
   function automatic int lane_count(input logic [1:0] vl);
      int n;
      case (vl)
         2'b00:   n = 1;
         2'b01:   n = 4;
         default: n = 16;
      endcase
      if (n > LANES) n = LANES;
      return n;
   endfunction

   // Spike counter accumulate that pins at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PC_W-1:0]  b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + (CNT_W+1)'(b);
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // Threshold compare, spike reset and popcount on the datapath result.
   always_comb begin
      upd_vol  = vol_q;
      upd_mask = '0;
      upd_cnt  = '0;
      lane_res = '0;
      act_n    = lane_count(vl_q);
      for (int i = 0; i < LANES; i++) begin
         if (i < act_n) begin
            lane_res = dp_vol_out[i*DW +: DW];
            if (lane_res >= vt_q) begin
               upd_mask[i]          = 1'b1;
               upd_cnt              = upd_cnt + 1'b1;
               upd_vol[i*DW +: DW]  = RESET_ON_SPIKE ? '0 : lane_res;
            end else begin
               upd_vol[i*DW +: DW]  = lane_res;
            end
         end
      end
   end

   // Run sequencing: next state and register updates.
   always_comb begin
      state_d    = state_q;
      vol_d      = vol_q;
      cur_d      = cur_q;
      vt_d       = vt_q;
      vl_d       = vl_q;
      steps_d    = steps_q;
      step_d     = step_q;
      spk_step_d = spk_step_q;
      mask_d     = mask_q;
      total_d    = total_q;
      err_d      = 1'b0;
      step_inc   = step_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_vl == 2'b11) begin
                  err_d = 1'b1;
               end else begin
                  vl_d    = cfg_vl;
                  vt_d    = cfg_vt;
                  steps_d = cfg_steps;
                  vol_d   = vol_init;
                  step_d  = '0;
                  total_d = '0;
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            state_d = (steps_q == '0) ? S_DONE : S_WAIT_CUR;
         end
         S_WAIT_CUR: begin
            if (cur_valid) begin
               cur_d   = cur_data;
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            mask_d     = upd_mask;
            vol_d      = upd_vol;
            total_d    = sat_add(total_q, upd_cnt);
            spk_step_d = step_q;
            state_d    = S_EMIT;
         end
         S_EMIT: begin
            if (spk_ready) begin
               step_d  = step_inc;
               state_d = (step_inc == steps_q) ? S_DONE : S_WAIT_CUR;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and data registers; reset clears everything and aborts a run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         vol_q      <= '0;
         cur_q      <= '0;
         vt_q       <= '0;
         vl_q       <= '0;
         steps_q    <= '0;
         step_q     <= '0;
         spk_step_q <= '0;
         mask_q     <= '0;
         total_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         vol_q      <= vol_d;
         cur_q      <= cur_d;
         vt_q       <= vt_d;
         vl_q       <= vl_d;
         steps_q    <= steps_d;
         step_q     <= step_d;
         spk_step_q <= spk_step_d;
         mask_q     <= mask_d;
         total_q    <= total_d;
         err_q      <= err_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign cur_ready   = (state_q == S_WAIT_CUR);
   assign spk_valid   = (state_q == S_EMIT);
   assign err         = err_q;
   assign dp_vol      = vol_q;
   assign dp_cur      = cur_q;
   assign dp_vt       = vt_q;
   assign dp_vl       = vl_q;
   assign spk_mask    = mask_q;
   assign spk_step    = spk_step_q;
   assign vol_final   = vol_q;
   assign spike_total = total_q;

endmodule

// File: tb/tb_neuron_step_ctrl.sv
// Bench for neuron_step_ctrl: leaky-integrate datapath stand-in, table of
// directed runs, hand-written corner sequences and randomized runs checked
// against a step-by-step reference model.
module tb_neuron_step_ctrl;

   localparam int LANES  = 16;
   localparam int DW     = 32;
   localparam int STEP_W = 8;
   localparam int CNT_W  = 6;   // small so the saturating counter can be reached
   localparam int MAXS   = 8;
   localparam int VW     = LANES * DW;
   localparam int SAT    = (1 << CNT_W) - 1;

   typedef logic [VW-1:0] vec_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [1:0]         cfg_vl = '0;
   logic [DW-1:0]      cfg_vt = '0;
   logic [STEP_W-1:0]  cfg_steps = '0;
   vec_t               vol_init = '0;
   logic               busy, done, err;
   logic               cur_valid = 1'b0;
   logic               cur_ready;
   vec_t               cur_data = '0;
   vec_t               dp_vol, dp_cur, dp_vol_out;
   logic [DW-1:0]      dp_vt;
   logic [1:0]         dp_vl;
   logic               spk_valid;
   logic               spk_ready = 1'b0;
   logic [LANES-1:0]   spk_mask;
   logic [STEP_W-1:0]  spk_step;
   vec_t               vol_final;
   logic [CNT_W-1:0]   spike_total;

   neuron_step_ctrl #(.LANES(LANES), .DW(DW), .STEP_W(STEP_W), .CNT_W(CNT_W),
                      .RESET_ON_SPIKE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_vl(cfg_vl), .cfg_vt(cfg_vt),
      .cfg_steps(cfg_steps), .vol_init(vol_init), .busy(busy), .done(done),
      .err(err), .cur_valid(cur_valid), .cur_ready(cur_ready),
      .cur_data(cur_data), .dp_vol(dp_vol), .dp_cur(dp_cur), .dp_vt(dp_vt),
      .dp_vl(dp_vl), .dp_vol_out(dp_vol_out), .spk_valid(spk_valid),
      .spk_ready(spk_ready), .spk_mask(spk_mask), .spk_step(spk_step),
      .vol_final(vol_final), .spike_total(spike_total)
   );

   always #5 clk = ~clk;

   // Leaky integrator stand-in for the external datapath: v - v/4 + i.
   always_comb begin
      dp_vol_out = '0;
      for (int i = 0; i < LANES; i++)
         dp_vol_out[i*DW +: DW] = dp_vol[i*DW +: DW] - (dp_vol[i*DW +: DW] >> 2)
                                  + dp_cur[i*DW +: DW];
   end

   int total = 0;
   int bad   = 0;

   vec_t             run_cur  [MAXS];
   logic [LANES-1:0] obs_mask [MAXS];
   int               obs_step [MAXS];
   int               nrec, obs_total, done_cyc;
   vec_t             obs_final;
   bit               done_seen, saw_ready;
   logic [LANES-1:0] exp_mask [MAXS];
   vec_t             exp_final;
   int               exp_total;

   task automatic chk(input string nm, input vec_t act, input vec_t expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Reference: per-step leaky update, unsigned threshold, clear on spike.
   task automatic model(input logic [1:0] vl, input logic [DW-1:0] vt,
                        input int steps, input vec_t v0);
      logic [DW-1:0] v [LANES];
      logic [DW-1:0] nv;
      int n, tot, cnt;
      n = (vl == 2'b00) ? 1 : (vl == 2'b01) ? 4 : 16;
      for (int i = 0; i < LANES; i++) v[i] = v0[i*DW +: DW];
      tot = 0;
      for (int s = 0; s < steps; s++) begin
         exp_mask[s] = '0;
         cnt = 0;
         for (int i = 0; i < n; i++) begin
            nv = v[i] - v[i] / 4 + run_cur[s][i*DW +: DW];
            if (nv >= vt) begin
               exp_mask[s][i] = 1'b1;
               cnt++;
               v[i] = '0;
            end else begin
               v[i] = nv;
            end
         end
         tot = tot + cnt;
         if (tot > SAT) tot = SAT;
      end
      for (int i = 0; i < LANES; i++) exp_final[i*DW +: DW] = v[i];
      exp_total = tot;
   endtask

   // Drive one complete run; stall_mode 0=ready at once, 1=hold 5 cycles,
   // 2=random valid/ready gaps. poke pulses start with altered cfg in EMIT.
   task automatic do_run(input logic [1:0] vl, input logic [DW-1:0] vt,
                         input int steps, input vec_t v0,
                         input int stall_mode, input bit poke);
      int  cyc, nc, stall;
      bit  in_emit, poked;
      nrec = 0; done_seen = 0; saw_ready = 0; nc = 0; stall = 0;
      in_emit = 0; poked = 0; done_cyc = -1;
      cfg_vl = vl; cfg_vt = vt; cfg_steps = STEP_W'(steps); vol_init = v0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_load", busy, 1);
      chk("dp_vt", dp_vt, vt);
      chk("dp_vl", dp_vl, vl);
      chk("dp_vol_init", dp_vol, v0);
      chk("total_clr", spike_total, 0);
      cyc = 0;
      while (cyc < 600 && !done_seen) begin
         cur_valid = 1'b0; spk_ready = 1'b0; start = 1'b0;
         if (done) begin
            done_seen = 1; done_cyc = cyc;
            obs_final = vol_final; obs_total = int'(spike_total);
         end else begin
            if (cur_ready) begin
               saw_ready = 1;
               if (nc < MAXS && (stall_mode != 2 || $urandom_range(0, 2) != 0)) begin
                  cur_valid = 1'b1; cur_data = run_cur[nc]; nc++;
               end
            end
            if (spk_valid) begin
               if (!in_emit) begin
                  in_emit = 1;
                  if (nrec < MAXS) begin
                     obs_mask[nrec] = spk_mask; obs_step[nrec] = int'(spk_step);
                  end
                  nrec++;
                  stall = (stall_mode == 1) ? 5 :
                          (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                  if (poke && !poked) begin
                     start = 1'b1; cfg_vt = '0; cfg_steps = 8'd50; cfg_vl = 2'b10;
                     poked = 1;
                  end
               end else if (nrec <= MAXS) begin
                  chk("hold_mask", spk_mask, obs_mask[nrec-1]);
                  chk("hold_step", spk_step, obs_step[nrec-1]);
                  chk("stall_cur_ready", cur_ready, 0);
               end
               if (stall > 0) stall--;
               else begin spk_ready = 1'b1; in_emit = 0; end
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      cur_valid = 1'b0; spk_ready = 1'b0; start = 1'b0;
      chk("done_seen", done_seen, 1);
      chk("done_gone", done, 0);
      chk("busy_after", busy, 0);
      chk("vol_final_hold", vol_final, obs_final);
      chk("cur_consumed", nc, steps);
      chk("cur_ready_seen", saw_ready, steps != 0);
   endtask

   task automatic check_model(input int steps);
      chk("nrec", nrec, steps);
      for (int k = 0; k < steps && k < nrec && k < MAXS; k++) begin
         chk("mask", obs_mask[k], exp_mask[k]);
         chk("step_idx", obs_step[k], k);
      end
      chk("vol_final", obs_final, exp_final);
      chk("spike_total", obs_total, exp_total);
   endtask

   typedef struct {
      logic [1:0]  vl;
      logic [31:0] vt;
      int          steps;
      logic [31:0] v0;
      logic [31:0] cur;
      int          stall;
      logic [15:0] exp_last_mask;
      logic [31:0] exp_act;
      int          exp_tot;
   } vec_rec_t;

   vec_rec_t tbl [10];
   vec_t     v0v, expv;
   int       n_act, h, cyc;

   initial begin
      tbl[0] = '{2'b00, 32'd120,        1, 32'd100,        32'd10,         0, 16'h0000, 32'd85,         0};
      tbl[1] = '{2'b01, 32'd150,        2, 32'd0,          32'd200,        1, 16'h000F, 32'd0,          8};
      tbl[2] = '{2'b10, 32'd5000,       3, 32'd1000,       32'd100,        0, 16'h0000, 32'd654,        0};
      tbl[3] = '{2'b10, 32'd0,          3, 32'd0,          32'd0,          0, 16'hFFFF, 32'd0,          48};
      tbl[4] = '{2'b00, 32'd300,        2, 32'd400,        32'd0,          0, 16'h0000, 32'd0,          1};
      tbl[5] = '{2'b01, 32'h10,         1, 32'hFFFFFFFC,   32'd8,          0, 16'h000F, 32'd0,          4};
      tbl[6] = '{2'b10, 32'd1,          0, 32'd77,         32'd0,          0, 16'h0000, 32'd77,         0};
      tbl[7] = '{2'b10, 32'd0,          5, 32'd0,          32'd0,          0, 16'hFFFF, 32'd0,          SAT};
      tbl[8] = '{2'b01, 32'h20000000,   1, 32'd0,          32'h20000000,   0, 16'h000F, 32'd0,          4};
      tbl[9] = '{2'b00, 32'h20000001,   1, 32'd0,          32'h20000000,   0, 16'h0000, 32'h20000000,   0};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_cur_ready", cur_ready, 0);
      chk("rst_spk_valid", spk_valid, 0);
      chk("rst_total", spike_total, 0);
      chk("rst_vol", dp_vol, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table.
      for (int t = 0; t < 10; t++) begin
         n_act = (tbl[t].vl == 2'b00) ? 1 : (tbl[t].vl == 2'b01) ? 4 : 16;
         for (int i = 0; i < LANES; i++) begin
            v0v[i*DW +: DW]  = tbl[t].v0;
            expv[i*DW +: DW] = (i < n_act) ? tbl[t].exp_act : tbl[t].v0;
         end
         for (int s = 0; s < MAXS; s++)
            for (int i = 0; i < LANES; i++) run_cur[s][i*DW +: DW] = tbl[t].cur;
         do_run(tbl[t].vl, tbl[t].vt, tbl[t].steps, v0v, tbl[t].stall, 1'b0);
         chk("tbl_nrec", nrec, tbl[t].steps);
         if (tbl[t].steps > 0 && nrec == tbl[t].steps)
            chk("tbl_last_mask", obs_mask[nrec-1], tbl[t].exp_last_mask);
         else
            chk("tbl_zero_lat", done_cyc, 1);
         chk("tbl_vol_final", obs_final, expv);
         chk("tbl_total", obs_total, tbl[t].exp_tot);
         @(posedge clk); #1;
      end

      // Illegal vector length.
      cfg_vl = 2'b11; cfg_steps = 8'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      @(posedge clk); #1;
      chk("err_gone", err, 0);
      chk("err_busy2", busy, 0);

      // Start while busy is ignored.
      for (int s = 0; s < MAXS; s++)
         for (int i = 0; i < LANES; i++) run_cur[s][i*DW +: DW] = 32'd60 + 32'(s * 40);
      for (int i = 0; i < LANES; i++) v0v[i*DW +: DW] = 32'd50;
      model(2'b01, 32'd120, 3, v0v);
      do_run(2'b01, 32'd120, 3, v0v, 0, 1'b1);
      check_model(3);
      chk("poke_vt", dp_vt, 32'd120);
      chk("poke_vl", dp_vl, 2'b01);
      @(posedge clk); #1;

      // Mid-run reset in WAIT_CUR of step 3 of 5.
      for (int i = 0; i < LANES; i++) v0v[i*DW +: DW] = '0;
      cfg_vl = 2'b01; cfg_vt = 32'd1000; cfg_steps = 8'd5; vol_init = v0v;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      h = 0; cyc = 0;
      while (cyc < 200 && !(cur_ready && h == 3)) begin
         cur_valid = cur_ready; cur_data = {LANES{32'd100}};
         spk_ready = spk_valid;
         if (spk_valid) h++;
         @(posedge clk); #1;
         cyc++;
      end
      cur_valid = 1'b0; spk_ready = 1'b0;
      chk("mid_reach", h, 3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_err", err, 0);
      chk("mid_cur_ready", cur_ready, 0);
      chk("mid_spk_valid", spk_valid, 0);
      chk("mid_mask", spk_mask, 0);
      chk("mid_step", spk_step, 0);
      chk("mid_total", spike_total, 0);
      chk("mid_vol", dp_vol, 0);
      chk("mid_cur", dp_cur, 0);
      chk("mid_vt", dp_vt, 0);
      chk("mid_vl", dp_vl, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int s = 0; s < MAXS; s++)
         for (int i = 0; i < LANES; i++) run_cur[s][i*DW +: DW] = 32'd300;
      model(2'b10, 32'd500, 4, v0v);
      do_run(2'b10, 32'd500, 4, v0v, 0, 1'b0);
      check_model(4);
      @(posedge clk); #1;

      // Randomized runs against the reference model.
      for (int r = 0; r < 24; r++) begin
         logic [1:0]    rvl;
         logic [DW-1:0] rvt;
         int            rst_cnt;
         rvl = 2'($urandom_range(0, 2));
         rvt = DW'($urandom_range(0, 3000));
         rst_cnt = int'($urandom_range(1, MAXS));
         for (int i = 0; i < LANES; i++) v0v[i*DW +: DW] = DW'($urandom_range(0, 2000));
         for (int s = 0; s < MAXS; s++)
            for (int i = 0; i < LANES; i++)
               run_cur[s][i*DW +: DW] = DW'($urandom_range(0, 1500));
         model(rvl, rvt, rst_cnt, v0v);
         do_run(rvl, rvt, rst_cnt, v0v, 2, 1'b0);
         check_model(rst_cnt);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/neuron_step_ctrl.md
Name: neuron_step_ctrl

Overview:
Sequencer that runs the combinational neuron-state update datapath over a multi-timestep run. It holds the membrane-voltage vector in a register and accepts one input-current vector per timestep over a valid/ready stream. Each timestep it drives the datapath, captures the updated voltages, and applies threshold spike detection and reset. It emits one spike mask per step and returns the final voltage vector to the vector-unit issue logic.

Parameters:
LANES, 16, number of 32-bit neuron lanes (datapath width = LANES*DW)
DW, 32, lane width in bits
STEP_W, 8, width of the timestep counter
CNT_W, 16, width of the per-run total spike counter
RESET_ON_SPIKE, 1, 1 = a spiking lane's stored voltage is cleared to 0; 0 = the updated value is kept

Ports:
clk  input  1  clock; all logic is rising-edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle run request; sampled only in IDLE
cfg_vl  input  2  vector length: 00=1 lane, 01=4, 10=16, 11=illegal
cfg_vt  input  DW  spike threshold (unsigned)
cfg_steps  input  STEP_W  number of timesteps in the run
vol_init  input  LANES*DW  initial voltage vector
busy  output  1  high from the cycle after an accepted start until DONE exits
done  output  1  one-cycle pulse at the end of a run
err  output  1  one-cycle pulse when start is given with cfg_vl=11
cur_valid  input  1  current vector valid
cur_ready  output  1  high only in WAIT_CUR
cur_data  input  LANES*DW  current vector
dp_vol  output  LANES*DW  voltage register driven to the datapath
dp_cur  output  LANES*DW  registered current driven to the datapath
dp_vt  output  DW  latched threshold
dp_vl  output  2  latched vector length
dp_vol_out  input  LANES*DW  combinational datapath result
spk_valid  output  1  spike record valid
spk_ready  input  1  spike record accepted
spk_mask  output  LANES  per-lane spike bits for this step
spk_step  output  STEP_W  index of this step, 0-based
vol_final  output  LANES*DW  voltage register; valid when done pulses
spike_total  output  CNT_W  spikes accumulated over the run; saturates at all-ones

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state = IDLE.
  - All outputs are 0: busy, done, err, cur_ready, spk_valid, spk_mask, spk_step, spike_total, and the vol/cur/vt/vl registers.
  - A reset in any state aborts the run. Nothing is emitted afterwards.
- IDLE:
  - start with cfg_vl=11: err pulses the next cycle; stay in IDLE.
  - start otherwise: latch cfg_vl, cfg_vt and cfg_steps; vol_reg = vol_init; step = 0; spike_total = 0; go to LOAD.
- LOAD: busy=1. If steps=0, go to DONE. Otherwise go to WAIT_CUR.
- WAIT_CUR:
  - cur_ready=1.
  - On cur_valid&cur_ready: cur_reg = cur_data; go to UPDATE.
- UPDATE (exactly one cycle):
  - The datapath sees dp_vol=vol_reg and dp_cur=cur_reg.
  - For each active lane i (i < lane count from VL):
    - spk_mask[i] = (dp_vol_out lane i >= vt), unsigned compare.
    - vol_reg lane i = 0 if the lane spikes and RESET_ON_SPIKE=1; otherwise vol_reg lane i = dp_vol_out lane i.
  - Inactive lanes: vol_reg unchanged and mask bit 0. dp_vol_out is ignored for those lanes.
  - spike_total += popcount(mask), saturating.
  - spk_step = step. Go to EMIT.
- EMIT:
  - spk_valid=1. mask and step are held stable until the handshake.
  - On spk_ready: step++. If step+1 == steps, go to DONE; otherwise go to WAIT_CUR.
- DONE:
  - done=1 for one cycle. vol_final and spike_total are valid this cycle and hold until the next start.
  - Next state is IDLE. busy drops the cycle after DONE.
- start is ignored while not in IDLE; it is not queued.
- Minimum step latency: 3 cycles (cur accept → UPDATE → EMIT with spk_ready already high).
- Voltage arithmetic wraps mod 2^DW inside the datapath. The controller does no arithmetic beyond the compare, the popcount and the counters.
- step wraps naturally. cfg_steps=2^STEP_W−1 is the maximum run length.

Test Plan:
- Single lane, no spike: VL=00, vol_init lane0=100, vt=120, steps=1, cur lane0=10 → datapath result 85; spk_mask=0x0000; vol_final lane0=85; done pulse; spike_total=0.
- Spike with reset: VL=01, vol_init=0, vt=150, steps=2, cur lanes0–3=200 every step.
  - step0: mask=0x000F, lanes0–3 cleared to 0.
  - step1: mask=0x000F again.
  - spike_total=8; lanes 4–15 unchanged.
- Backpressure: hold spk_ready=0 for 5 cycles in EMIT → spk_valid, spk_mask and spk_step stable; cur_ready stays 0 during the stall; run resumes on ready.
- Illegal VL and zero steps:
  - start with cfg_vl=11 → err pulses once; busy stays 0.
  - start with steps=0 → done one cycle after LOAD; cur_ready never asserted; vol_final=vol_init.
- Mid-run reset: assert rst_n=0 during WAIT_CUR of step 3 of 5 → the next cycle has all outputs 0 and state IDLE. A following start runs cleanly from step 0.
- Start while busy is ignored: pulse start during EMIT → no re-latch of cfg; the run completes with the original steps and vt.
